aes_decipher_engine: RTL and testbench
======================================

# aes_decipher_engine

Iterative, parametrised AES inverse-cipher datapath with its own control FSM, round counter and byte-lane counter. It takes one 128-bit ciphertext block and drives round-key addresses to the external key memory. It returns the plaintext after a deterministic number of cycles. It supports AES-128/192/256 and a configurable number of parallel inverse S-box lanes, trading area against latency. It sits between the core's control/register interface and the shared key-expansion memory.

## Interface
- SBOX_LANES, 4: inverse S-box instances used per cycle. Legal values are 1, 2, 4, 8, 16. S = 16/SBOX_LANES substitution cycles per round.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- next  in  1  start request; sampled only while ready=1.
- keylen  in  2  key-length select: 2'h0 = 128, 2'h1 = 192, 2'h2 = 256, 2'h3 = treated as 128. Latched on accept.
- round_key_addr  out  4  registered; equals the internal round counter.
- round_key  in  128  key word for round_key_addr. Valid combinationally in the same cycle.
- block  in  128  ciphertext; latched on accept.
- new_block  out  128  state register; holds plaintext when ready=1 after a run.
- ready  out  1  idle/done flag.
- abort  in  1  present only with AES_DECIPHER_ABORT_EN.

## Operation
- Nr is 10, 12 or 14, selected from the latched keylen.
- States:
  - IDLE
  - INIT: AddRoundKey with round_key[Nr].
  - SHIFT: InvShiftRows.
  - SBOX: InvSubBytes, SBOX_LANES bytes per cycle.
  - MIX: AddRoundKey then InvMixColumns.
  - FINAL: AddRoundKey only.
- IDLE, with next=1: block_reg <= block, round_ctr <= Nr, keylen latched, ready <= 0, go to INIT.
- INIT: block_reg ^= round_key, round_ctr <= Nr-1, go to SHIFT.
- SHIFT: block_reg <= InvShiftRows(block_reg), sword_ctr <= 0, go to SBOX.
- SBOX: bytes [sword_ctr*L +: L] (big-endian byte index 0 = bits 127:120) are replaced by inv_sbox, where L = SBOX_LANES.
  - sword_ctr increments each cycle.
  - When sword_ctr = S-1: go to MIX if round_ctr != 0, otherwise go to FINAL.
- MIX: block_reg <= InvMixColumns(block_reg ^ round_key), round_ctr decrements, go to SHIFT.
- FINAL: block_reg ^= round_key[0], ready <= 1, go to IDLE.
- next while ready=0 is ignored. keylen, block and next changes mid-run have no effect.
- sword_ctr wraps modulo S. When S = 1 the counter is constant 0.
- Reset values: ready = 1, new_block = 0, round_key_addr = 0, state = IDLE, all counters = 0.
- Reset asserted mid-run returns to the reset values immediately. No partial plaintext remains visible.

## Timing
- ready falls on the edge after the accept edge.
- ready rises exactly 1 + Nr*(S+2) cycles after the accept edge.
  - SBOX_LANES=4, AES-128: 61 cycles.
  - SBOX_LANES=16, AES-256: 43 cycles.
- new_block is stable from the ready rise until the next accept.
- next asserted in the same cycle ready rises is accepted. Back-to-back operation has zero idle cycles.
- round_key_addr changes only on edges. The key memory must provide round_key within the same cycle.

## Configuration
- AES_DECIPHER_ABORT_EN defined:
  - Adds the abort input.
  - abort=1 in any non-IDLE state forces IDLE on the next edge, with block_reg <= 0, ready <= 1, round_ctr <= 0.
  - abort in IDLE has no effect.
  - abort has priority over the state transition in the same cycle.
- AES_DECIPHER_ABORT_EN undefined: the port is absent and every accepted run completes.

## Structure
- Shared package aes_pkg holds:
  - keylen encodings AES_128/192/256_BIT_KEY.
  - round counts AES128/192/256_ROUNDS.
  - the state enum.
  - the gm2/gm09/gm11/gm13/gm14 functions and the inv_shift_rows function.
- Instantiate the existing aes_inv_sbox SBOX_LANES times via a generate loop.
- One new sub-module, aes_inv_mixcolumns: purely combinational, 128-bit in to 128-bit out.

## Test plan
- AES-128, L=4, FIPS-197 C.1: ct 69c4e0d86a7b0430d8cdb78070b4c55a, bench key memory from key 000102…0f.
  - Required: pt 00112233445566778899aabbccddeeff; ready low for exactly 61 cycles.
- AES-192 C.2 (dda97ca4864cdfe06eaf70a0ec0d7191) and AES-256 C.3 (8ea2b7ca516745bfeafc49904b496089), each at L=1, 4 and 16.
  - Required: pt 00112233…eeff; latency 1 + Nr*(S+2) in every case.
  - Required: round_key_addr sequence Nr, Nr-1, …, 0, each address held for the documented cycles.
- next held high continuously for 3 blocks.
  - Required: 3 correct outputs; ready high exactly one cycle between runs; next pulses while busy ignored.
- Reset asserted at cycle 20 of a run.
  - Required: new_block = 0 and ready = 1 immediately; a following run is correct.
- With AES_DECIPHER_ABORT_EN, abort in an SBOX cycle.
  - Required: ready = 1 and new_block = 0 on the next edge; a following C.1 run is correct.
- keylen = 2'h3 with the C.1 vectors.
  - Required: identical behaviour to AES-128.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES key-length encodings, round counts, state codes and GF(2^8) helpers
package aes_pkg;

  localparam logic [1:0] AES_128_BIT_KEY = 2'h0;
  localparam logic [1:0] AES_192_BIT_KEY = 2'h1;
  localparam logic [1:0] AES_256_BIT_KEY = 2'h2;

  localparam logic [3:0] AES128_ROUNDS = 4'd10;
  localparam logic [3:0] AES192_ROUNDS = 4'd12;
  localparam logic [3:0] AES256_ROUNDS = 4'd14;

  typedef logic [2:0] aes_state_t;
  localparam aes_state_t ST_IDLE  = 3'd0;
  localparam aes_state_t ST_INIT  = 3'd1;
  localparam aes_state_t ST_SHIFT = 3'd2;
  localparam aes_state_t ST_SBOX  = 3'd3;
  localparam aes_state_t ST_MIX   = 3'd4;
  localparam aes_state_t ST_FINAL = 3'd5;

  // The unused encoding 2'h3 falls back to AES-128.
  function automatic logic [3:0] num_rounds(input logic [1:0] keylen);
    case (keylen)
      AES_128_BIT_KEY: return AES128_ROUNDS;
      AES_192_BIT_KEY: return AES192_ROUNDS;
      AES_256_BIT_KEY: return AES256_ROUNDS;
      default:         return AES128_ROUNDS;
    endcase
  endfunction

  function automatic logic [7:0] gm2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm09(input logic [7:0] b);
    return gm2(gm2(gm2(b))) ^ b;
  endfunction

  function automatic logic [7:0] gm11(input logic [7:0] b);
    return gm2(gm2(gm2(b)) ^ b) ^ b;
  endfunction

  function automatic logic [7:0] gm13(input logic [7:0] b);
    return gm2(gm2(gm2(b) ^ b)) ^ b;
  endfunction

  function automatic logic [7:0] gm14(input logic [7:0] b);
    return gm2(gm2(gm2(b) ^ b) ^ b);
  endfunction

  // Columns are 32-bit words, column 0 in bits 127:96; row r rotates right by r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [31:0] w0, w1, w2, w3;
    w0 = s[127:96];
    w1 = s[95:64];
    w2 = s[63:32];
    w3 = s[31:0];
    return {w0[31:24], w3[23:16], w2[15:8], w1[7:0],
            w1[31:24], w0[23:16], w3[15:8], w2[7:0],
            w2[31:24], w1[23:16], w0[15:8], w3[7:0],
            w3[31:24], w2[23:16], w1[15:8], w0[7:0]};
  endfunction

endpackage

// File: rtl/aes_decipher_engine_if.sv
// rtl/aes_decipher_engine_if.sv - control and key-memory bundle of the decipher engine
// The abort signal exists only when AES_DECIPHER_ABORT_EN is defined.
interface aes_decipher_engine_if;

  logic         next;
  logic [1:0]   keylen;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;
  logic [3:0]   round_key_addr;
  logic [127:0] round_key;
`ifdef AES_DECIPHER_ABORT_EN
  logic         abort;

  modport master (output next, keylen, block, round_key, abort,
                  input  new_block, ready, round_key_addr);
  modport slave  (input  next, keylen, block, round_key, abort,
                  output new_block, ready, round_key_addr);
`else
  modport master (output next, keylen, block, round_key,
                  input  new_block, ready, round_key_addr);
  modport slave  (input  next, keylen, block, round_key,
                  output new_block, ready, round_key_addr);
`endif

endinterface

// File: rtl/aes_inv_mixcolumns.sv
// rtl/aes_inv_mixcolumns.sv - combinational InvMixColumns over a full 128-bit state
module aes_inv_mixcolumns
  import aes_pkg::*;
(
  input  logic [127:0] data_in,
  output logic [127:0] data_out
);

  function automatic logic [31:0] inv_mix_word(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gm14(a0) ^ gm11(a1) ^ gm13(a2) ^ gm09(a3),
            gm09(a0) ^ gm14(a1) ^ gm11(a2) ^ gm13(a3),
            gm13(a0) ^ gm09(a1) ^ gm14(a2) ^ gm11(a3),
            gm11(a0) ^ gm13(a1) ^ gm09(a2) ^ gm14(a3)};
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign data_out[127 - 32*c -: 32] = inv_mix_word(data_in[127 - 32*c -: 32]);
  end

endmodule

// File: rtl/aes_inv_sbox.sv
// rtl/aes_inv_sbox.sv - single-byte AES inverse S-box lookup
module aes_inv_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign out_byte = INV_SBOX[in_byte];

endmodule

// File: rtl/aes_decipher_engine.sv
// rtl/aes_decipher_engine.sv - iterative AES-128/192/256 inverse cipher with SBOX_LANES S-box lanes
// Optional feature: AES_DECIPHER_ABORT_EN adds an abort that returns a running engine to idle.
module aes_decipher_engine
  import aes_pkg::*;
#(
  parameter int SBOX_LANES = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  aes_decipher_engine_if.slave bus
);

  localparam int S  = 16 / SBOX_LANES;
  localparam int SW = (S > 1) ? $clog2(S) : 1;

  aes_state_t   state;
  logic [127:0] block_reg;
  logic [3:0]   round_ctr;
  logic [SW-1:0] sword_ctr;
  logic [1:0]   keylen_reg;
  logic         ready_reg;

  logic [127:0] keyed;
  logic [127:0] mix_out;
  logic [127:0] sub_block;
  logic [3:0]   base_byte;
  logic         last_sword;
  logic         abort_hit;
  logic [7:0]   sbox_in  [SBOX_LANES];
  logic [7:0]   sbox_out [SBOX_LANES];
  logic [6:0]   lane_pos [SBOX_LANES];

  assign keyed      = block_reg ^ bus.round_key;
  assign last_sword = (sword_ctr == SW'(S - 1));
  assign base_byte  = 4'(sword_ctr) * 4'(SBOX_LANES);

`ifdef AES_DECIPHER_ABORT_EN
  assign abort_hit = bus.abort && (state != ST_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // Lane j handles byte base_byte+j; byte 0 sits in bits 127:120.
  for (genvar j = 0; j < SBOX_LANES; j++) begin : g_lane
    logic [3:0] idx;
    assign idx         = base_byte + 4'(j);
    assign lane_pos[j] = {~idx, 3'b000};
    assign sbox_in[j]  = block_reg[lane_pos[j] +: 8];
    aes_inv_sbox u_inv_sbox (
      .in_byte  (sbox_in[j]),
      .out_byte (sbox_out[j])
    );
  end

  always_comb begin
    sub_block = block_reg;
    for (int j = 0; j < SBOX_LANES; j++) begin
      sub_block[lane_pos[j] +: 8] = sbox_out[j];
    end
  end

  aes_inv_mixcolumns u_inv_mixcolumns (
    .data_in  (keyed),
    .data_out (mix_out)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      block_reg  <= '0;
      round_ctr  <= '0;
      sword_ctr  <= '0;
      keylen_reg <= '0;
      ready_reg  <= 1'b1;
    end else if (abort_hit) begin
      state     <= ST_IDLE;
      block_reg <= '0;
      round_ctr <= '0;
      sword_ctr <= '0;
      ready_reg <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.next) begin
            block_reg  <= bus.block;
            round_ctr  <= num_rounds(bus.keylen);
            keylen_reg <= bus.keylen;
            ready_reg  <= 1'b0;
            state      <= ST_INIT;
          end
        end
        ST_INIT: begin
          block_reg <= keyed;
          round_ctr <= num_rounds(keylen_reg) - 4'd1;
          state     <= ST_SHIFT;
        end
        ST_SHIFT: begin
          block_reg <= inv_shift_rows(block_reg);
          sword_ctr <= '0;
          state     <= ST_SBOX;
        end
        ST_SBOX: begin
          block_reg <= sub_block;
          if (last_sword) begin
            sword_ctr <= '0;
            state     <= (round_ctr != 4'd0) ? ST_MIX : ST_FINAL;
          end else begin
            sword_ctr <= sword_ctr + SW'(1);
          end
        end
        ST_MIX: begin
          block_reg <= mix_out;
          round_ctr <= round_ctr - 4'd1;
          state     <= ST_SHIFT;
        end
        ST_FINAL: begin
          block_reg <= keyed;
          ready_reg <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.new_block      = block_reg;
  assign bus.ready          = ready_reg;
  assign bus.round_key_addr = round_ctr;

endmodule

// File: tb/tb_aes_decipher_engine.sv
// tb/tb_aes_decipher_engine.sv - directed FIPS-197 vectors on three lane configurations in parallel
// Covers abort behaviour only when AES_DECIPHER_ABORT_EN is defined.
module tb_aes_decipher_engine;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam int           LANES [3] = '{1, 4, 16};

  logic         clk;
  logic         reset_n;
  logic         next_drv;
  logic [1:0]   kl;
  logic [127:0] ct;
  logic         rdy [3];
  logic [3:0]   adr [3];
  logic [127:0] nb  [3];
  logic [127:0] rk_tab [3][16];
  logic [7:0]   sbox_t [256];
  int           n_vec = 0;
  int           n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] rk_of(input logic [1:0] k, input logic [3:0] a);
    int sel;
    sel = (k == 2'h1) ? 1 : (k == 2'h2) ? 2 : 0;
    return rk_tab[sel][a];
  endfunction

  aes_decipher_engine_if bus_if [3] ();
`ifdef AES_DECIPHER_ABORT_EN
  logic abort_drv;
`endif

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_decipher_engine #(.SBOX_LANES(LANES[g])) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_if[g])
    );
    assign bus_if[g].next      = next_drv;
    assign bus_if[g].keylen    = kl;
    assign bus_if[g].block     = ct;
    assign bus_if[g].round_key = rk_of(kl, bus_if[g].round_key_addr);
`ifdef AES_DECIPHER_ABORT_EN
    assign bus_if[g].abort     = abort_drv;
`endif
    assign rdy[g] = bus_if[g].ready;
    assign adr[g] = bus_if[g].round_key_addr;
    assign nb[g]  = bus_if[g].new_block;
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b  = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  // Forward S-box from its algebraic definition: GF inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // Key schedule for the key 00 01 02 ... of nk words.
  task automatic expand_key(input int sel, input int nk, input int nr);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i + 1), 8'(4*i + 2), 8'(4*i + 3)};
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) rk_tab[sel][r] = '0;
    for (int r = 0; r <= nr; r++) rk_tab[sel][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_addr(input int nr, input int s, input int cyc);
    return (cyc == 1) ? nr : nr - 1 - (cyc - 2) / (s + 2);
  endfunction

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(rdy[0] && rdy[1] && rdy[2]) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 128'({rdy[0], rdy[1], rdy[2]}), 128'h7);
  endtask

  // Starts all three engines together and follows each until its ready rises.
  task automatic run_block(input string tag, input logic [1:0] key_sel, input logic [127:0] cipher, input int nr);
    int lat [3];
    int addr_bad [3];
    bit done [3];
    int cyc;
    for (int i = 0; i < 3; i++) begin
      lat[i] = -1;
      addr_bad[i] = 0;
      done[i] = 1'b0;
    end
    @(negedge clk);
    kl = key_sel;
    ct = cipher;
    next_drv = 1'b1;
    @(posedge clk); #1;
    next_drv = 1'b0;
    cyc = 1;
    while (!(done[0] && done[1] && done[2]) && cyc <= 400) begin
      for (int i = 0; i < 3; i++) begin
        if (!done[i]) begin
          if (rdy[i]) begin
            done[i] = 1'b1;
            lat[i] = cyc - 1;
          end else if (int'(adr[i]) != exp_addr(nr, 16 / LANES[i], cyc)) begin
            addr_bad[i]++;
          end
        end
      end
      // A stray start request and a new block mid-run must both be ignored.
      next_drv = (cyc == 5);
      if (cyc == 5) ct = ~cipher;
      @(posedge clk); #1;
      cyc++;
    end
    next_drv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s L%0d latency", tag, LANES[i]), 128'(lat[i]), 128'(1 + nr * (16 / LANES[i] + 2)));
      check($sformatf("%s L%0d plaintext", tag, LANES[i]), nb[i], PT);
      check($sformatf("%s L%0d addr_seq", tag, LANES[i]), 128'(addr_bad[i]), 128'd0);
    end
  endtask

  initial begin
    int cnt;
    reset_n  = 1'b0;
    next_drv = 1'b0;
    kl       = 2'h0;
    ct       = '0;
`ifdef AES_DECIPHER_ABORT_EN
    abort_drv = 1'b0;
`endif
    build_sbox();
    expand_key(0, 4, 10);
    expand_key(1, 6, 12);
    expand_key(2, 8, 14);

    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset L%0d ready", LANES[i]), 128'(rdy[i]), 128'd1);
      check($sformatf("reset L%0d new_block", LANES[i]), nb[i], 128'd0);
      check($sformatf("reset L%0d addr", LANES[i]), 128'(adr[i]), 128'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    run_block("c1_aes128", 2'h0, CT128, 10);
    run_block("c2_aes192", 2'h1, CT192, 12);
    run_block("c3_aes256", 2'h2, CT256, 14);
    run_block("keylen3", 2'h3, CT128, 10);

    // next held high: the L=4 engine restarts with exactly one ready cycle between runs.
    @(negedge clk);
    kl = 2'h0;
    ct = CT128;
    next_drv = 1'b1;
    @(posedge clk); #1;
    for (int r = 0; r < 3; r++) begin
      cnt = 0;
      while (!rdy[1] && cnt < 200) begin
        @(posedge clk); #1;
        cnt++;
      end
      check($sformatf("b2b run%0d latency", r), 128'(cnt), 128'd61);
      check($sformatf("b2b run%0d plaintext", r), nb[1], PT);
      @(posedge clk); #1;
      check($sformatf("b2b run%0d reaccept", r), 128'(rdy[1]), 128'd0);
    end
    next_drv = 1'b0;
    wait_idle("b2b idle");

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    kl = 2'h0;
    ct = CT128;
    next_drv = 1'b1;
    @(posedge clk); #1;
    next_drv = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("midrst L%0d ready", LANES[i]), 128'(rdy[i]), 128'd1);
      check($sformatf("midrst L%0d new_block", LANES[i]), nb[i], 128'd0);
      check($sformatf("midrst L%0d addr", LANES[i]), 128'(adr[i]), 128'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    run_block("post_reset", 2'h0, CT128, 10);

`ifdef AES_DECIPHER_ABORT_EN
    // Abort during the first SBOX cycle of every engine.
    @(negedge clk);
    kl = 2'h0;
    ct = CT128;
    next_drv = 1'b1;
    @(posedge clk); #1;
    next_drv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    abort_drv = 1'b1;
    @(posedge clk); #1;
    abort_drv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("abort L%0d ready", LANES[i]), 128'(rdy[i]), 128'd1);
      check($sformatf("abort L%0d new_block", LANES[i]), nb[i], 128'd0);
    end
    @(negedge clk);
    abort_drv = 1'b1;
    @(posedge clk); #1;
    abort_drv = 1'b0;
    check("abort idle L4 ready", 128'(rdy[1]), 128'd1);
    run_block("post_abort", 2'h0, CT128, 10);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
